// File: rtl/hc_sched.sv
// Control sequencer for an HC-128 style keystream core: key/IV load, W expansion,
// 1024-step table initialisation, then one cipher step per keystream request.
module hc_sched #(
  parameter int STEP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        next,
  output logic        ready,
  output logic        load_we,
  output logic        expand_we,
  output logic [10:0] expand_idx,
  output logic        update,
  output logic        init_mode,
  output logic        table_sel,
  output logic [8:0]  j,
  output logic [8:0]  addr_m3,
  output logic [8:0]  addr_m10,
  output logic [8:0]  addr_m12,
  output logic [8:0]  addr_p1,
  output logic        tbl_we,
  output logic        s_we,
  output logic        s_valid
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_EXPAND   = 3'd2;
  localparam logic [2:0] S_INIT_RUN = 3'd3;
  localparam logic [2:0] S_READY    = 3'd4;
  localparam logic [2:0] S_GEN      = 3'd5;

  localparam logic [1:0]  SUB_LAST     = 2'(STEP_CYCLES - 1);
  localparam logic [10:0] LOAD_LAST    = 11'd15;
  localparam logic [10:0] EXPAND_LAST  = 11'd1279;
  localparam logic [9:0]  STEP_LAST    = 10'd1023;

  logic [2:0]  state_q, state_d;
  logic [10:0] idx_q, idx_d;
  logic [9:0]  i_q, i_d;
  logic [1:0]  sub_q, sub_d;
  logic        s_valid_q, s_valid_d;
  logic        step_last;
  logic        stepping;
  logic        abort;
  logic [8:0]  j_raw;

  assign step_last = (sub_q == SUB_LAST);
  assign stepping  = (state_q == S_INIT_RUN) || (state_q == S_GEN);
  assign abort     = init | reset;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    i_d       = i_q;
    sub_d     = sub_q;
    s_valid_d = s_valid_q;
    // init restarts the whole key schedule from any state, and beats next
    if (init) begin
      state_d   = S_LOAD;
      idx_d     = '0;
      i_d       = '0;
      sub_d     = '0;
      s_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_LOAD: begin
          idx_d = idx_q + 11'd1;
          if (idx_q == LOAD_LAST) state_d = S_EXPAND;
        end
        S_EXPAND: begin
          if (idx_q == EXPAND_LAST) begin
            state_d = S_INIT_RUN;
            idx_d   = '0;
            i_d     = '0;
            sub_d   = '0;
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
        S_INIT_RUN: begin
          if (step_last) begin
            sub_d = '0;
            i_d   = i_q + 10'd1;
            if (i_q == STEP_LAST) state_d = S_READY;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
        S_READY: begin
          if (next) begin
            state_d   = S_GEN;
            sub_d     = '0;
            s_valid_d = 1'b0;
          end
        end
        S_GEN: begin
          if (step_last) begin
            sub_d     = '0;
            i_d       = i_q + 10'd1;
            state_d   = S_READY;
            s_valid_d = 1'b1;
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      i_q       <= '0;
      sub_q     <= '0;
      s_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      i_q       <= i_d;
      sub_q     <= sub_d;
      s_valid_q <= s_valid_d;
    end
  end

  // Step addressing is only driven while a step runs; 9-bit arithmetic gives the mod-512 wrap
  assign j_raw      = i_q[8:0];
  assign ready      = (state_q == S_READY);
  assign load_we    = (state_q == S_LOAD);
  assign expand_we  = (state_q == S_EXPAND);
  assign expand_idx = (load_we || expand_we) ? idx_q : 11'd0;
  assign update     = stepping;
  assign init_mode  = (state_q == S_INIT_RUN);
  assign table_sel  = stepping & i_q[9];
  assign j          = stepping ? j_raw : 9'd0;
  assign addr_m3    = stepping ? (j_raw - 9'd3)  : 9'd0;
  assign addr_m10   = stepping ? (j_raw - 9'd10) : 9'd0;
  assign addr_m12   = stepping ? (j_raw - 9'd12) : 9'd0;
  assign addr_p1    = stepping ? (j_raw + 9'd1)  : 9'd0;
  assign tbl_we     = stepping & step_last & ~abort;
  assign s_we       = (state_q == S_GEN) & step_last & ~abort;
  assign s_valid    = s_valid_q;

endmodule

// File: tb/tb_hc_sched.sv
// Directed + randomized bench for hc_sched; expectations come from step/phase
// counting in the bench (load 16, expand 1264, 1024 init steps, keystream steps).
module tb_hc_sched;

  localparam int STEP = 2;

  logic        clk = 1'b0;
  logic        reset, init, nxt;
  logic        ready, load_we, expand_we, update, init_mode, table_sel;
  logic        tbl_we, s_we, s_valid;
  logic [10:0] expand_idx;
  logic [8:0]  j, addr_m3, addr_m10, addr_m12, addr_p1;

  int checks   = 0;
  int failures = 0;
  int ks_i     = 0;

  hc_sched #(.STEP_CYCLES(STEP)) dut (
    .clk(clk), .reset(reset), .init(init), .next(nxt),
    .ready(ready), .load_we(load_we), .expand_we(expand_we),
    .expand_idx(expand_idx), .update(update), .init_mode(init_mode),
    .table_sel(table_sel), .j(j), .addr_m3(addr_m3), .addr_m10(addr_m10),
    .addr_m12(addr_m12), .addr_p1(addr_p1), .tbl_we(tbl_we), .s_we(s_we),
    .s_valid(s_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int wrap512(input int v);
    return ((v % 512) + 512) % 512;
  endfunction

  task automatic chk_quiet(input string tag, input logic exp_ready, input logic exp_sv);
    chk({tag, ".ready"}, ready, exp_ready);
    chk({tag, ".s_valid"}, s_valid, exp_sv);
    chk({tag, ".update"}, update, 0);
    chk({tag, ".load_we"}, load_we, 0);
    chk({tag, ".expand_we"}, expand_we, 0);
    chk({tag, ".tbl_we"}, tbl_we, 0);
    chk({tag, ".s_we"}, s_we, 0);
  endtask

  task automatic step_checks(input string tag, input int step, input bit init_ph, input int sub);
    chk({tag, ".update"}, update, 1);
    chk({tag, ".load_we"}, load_we, 0);
    chk({tag, ".expand_we"}, expand_we, 0);
    chk({tag, ".ready"}, ready, 0);
    chk({tag, ".init_mode"}, init_mode, init_ph);
    chk({tag, ".j"}, j, step % 512);
    chk({tag, ".table_sel"}, table_sel, step / 512);
    chk({tag, ".addr_m3"}, addr_m3, wrap512(step - 3));
    chk({tag, ".addr_m10"}, addr_m10, wrap512(step - 10));
    chk({tag, ".addr_m12"}, addr_m12, wrap512(step - 12));
    chk({tag, ".addr_p1"}, addr_p1, wrap512(step + 1));
    chk({tag, ".tbl_we"}, tbl_we, (sub == STEP - 1));
    chk({tag, ".s_we"}, s_we, (!init_ph && sub == STEP - 1));
  endtask

  // Called in the first LOAD cycle; ends in the first READY cycle.
  task automatic run_init_body(input bit noisy_next);
    for (int k = 0; k < 16; k++) begin
      chk("load.we", load_we, 1);
      chk("load.idx", expand_idx, k);
      chk("load.expand_we", expand_we, 0);
      chk("load.update", update, 0);
      chk("load.ready", ready, 0);
      chk("load.s_valid", s_valid, 0);
      if (noisy_next) nxt = 1'($urandom_range(0, 1));
      cyc();
    end
    for (int k = 16; k < 1280; k++) begin
      chk("expand.we", expand_we, 1);
      chk("expand.idx", expand_idx, k);
      chk("expand.load_we", load_we, 0);
      chk("expand.update", update, 0);
      chk("expand.ready", ready, 0);
      if (noisy_next) nxt = 1'($urandom_range(0, 1));
      cyc();
    end
    for (int s = 0; s < 1024; s++) begin
      for (int sub = 0; sub < STEP; sub++) begin
        step_checks("initrun", s, 1'b1, sub);
        if (noisy_next) nxt = 1'($urandom_range(0, 1));
        cyc();
      end
    end
    nxt = 1'b0;
    chk_quiet("init_done", 1'b1, 1'b0);
    ks_i = 0;
  endtask

  task automatic gen_step();
    nxt = 1'b1;
    cyc();
    nxt = 1'b0;
    for (int sub = 0; sub < STEP; sub++) begin
      chk("gen.s_valid_low", s_valid, 0);
      step_checks("gen", ks_i, 1'b0, sub);
      cyc();
    end
    chk_quiet("gen_done", 1'b1, 1'b1);
    ks_i = (ks_i + 1) % 1024;
    repeat ($urandom_range(0, 2)) begin
      chk_quiet("gen_gap", 1'b1, 1'b1);
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1;
    init  = 1'b0;
    nxt   = 1'b0;
    @(negedge clk);
    repeat (3) cyc();
    reset = 1'b0;

    chk_quiet("reset", 1'b0, 1'b0);
    chk("reset.expand_idx", expand_idx, 0);
    chk("reset.j", j, 0);
    chk("reset.addr_m3", addr_m3, 0);
    chk("reset.addr_p1", addr_p1, 0);
    chk("reset.table_sel", table_sel, 0);
    chk("reset.init_mode", init_mode, 0);

    // next while unkeyed is ignored
    nxt = 1'b1;
    cyc();
    nxt = 1'b0;
    repeat (4) begin
      chk_quiet("unkeyed_next", 1'b0, 1'b0);
      cyc();
    end

    // full init with busy-time next noise, exact 3328-cycle latency
    init = 1'b1;
    cyc();
    init = 1'b0;
    run_init_body(1'b1);

    // 1025 keystream steps: table Q on 512..1023, wrap back to j=0/P
    for (int n = 0; n < 1025; n++) gen_step();

    // init during GEN sub-cycle 0 aborts with no strobes
    nxt = 1'b1;
    cyc();
    nxt = 1'b0;
    init = 1'b1;
    chk("abort_gen.update", update, 1);
    chk("abort_gen.s_we", s_we, 0);
    chk("abort_gen.tbl_we", tbl_we, 0);
    chk("abort_gen.s_valid", s_valid, 0);
    cyc();
    init = 1'b0;
    run_init_body(1'b0);

    // init at a random point of load/expand/init-run restarts cleanly
    init = 1'b1;
    cyc();
    init = 1'b0;
    repeat ($urandom_range(20, 3000)) cyc();
    init = 1'b1;
    cyc();
    init = 1'b0;
    run_init_body(1'b0);
    repeat (3) gen_step();

    // init and next together in READY: init wins, no GEN step
    init = 1'b1;
    nxt  = 1'b1;
    cyc();
    init = 1'b0;
    nxt  = 1'b0;
    run_init_body(1'b0);
    repeat (2) gen_step();

    // reset with init goes to IDLE, block unkeyed afterwards
    reset = 1'b1;
    init  = 1'b1;
    cyc();
    reset = 1'b0;
    init  = 1'b0;
    chk_quiet("reset_init", 1'b0, 1'b0);
    chk("reset_init.expand_idx", expand_idx, 0);
    nxt = 1'b1;
    cyc();
    nxt = 1'b0;
    repeat (4) begin
      chk_quiet("post_reset_next", 1'b0, 1'b0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hc_sched.md
HC_SCHED -- requirements
Module: hc_sched

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 2, clock cycles per cipher step (legal range 2..4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port init  input  1  start key/IV load and table initialisation.
REQ-005 SHALL have port next  input  1  request one keystream word.
REQ-006 SHALL have port ready  output  1  idle and keyed; accepts next.
REQ-007 SHALL have port load_we  output  1  write key/IV word expand_idx (0..15) into W.
REQ-008 SHALL have port expand_we  output  1  compute and write expansion word expand_idx (16..1279).
REQ-009 SHALL have port expand_idx  output  11  expansion word index.
REQ-010 SHALL have port update  output  1  cipher step in progress.
REQ-011 SHALL have port init_mode  output  1  step result is fed back into the table, not output.
REQ-012 SHALL have port table_sel  output  1  0 = P updated, 1 = Q updated.
REQ-013 SHALL have port j  output  9  step index, i mod 512.
REQ-014 SHALL have port addr_m3 / addr_m10 / addr_m12 / addr_p1  output  9 each  (j-3), (j-10), (j-12), (j+1) mod 512.
REQ-015 SHALL have port tbl_we  output  1  table write strobe for entry j.
REQ-016 SHALL have port s_we  output  1  latch keystream word.
REQ-017 SHALL have port s_valid  output  1  keystream word valid.

Function
REQ-018 SHALL implement states IDLE, LOAD, EXPAND, INIT_RUN, READY, GEN.
REQ-019 IDLE: ready=0; next ignored; init -> LOAD.
REQ-020 LOAD: 16 cycles; load_we=1; expand_idx = 0..15, one per cycle; then -> EXPAND.
REQ-021 EXPAND: 1264 cycles; expand_we=1; expand_idx = 16..1279, one per cycle; then -> INIT_RUN with 10-bit step counter i=0.
REQ-022 INIT_RUN: 1024 steps of STEP_CYCLES cycles each; update=1, init_mode=1; after step 1023, i wraps to 0 -> READY.
REQ-023 Each step: sub-cycle counter 0..STEP_CYCLES-1; tbl_we=1 only in the last sub-cycle; i increments mod 1024 after the last sub-cycle.
REQ-024 Addressing: table_sel=i[9]; j=i[8:0]; all address outputs wrap mod 512 (j=0 -> addr_m3=509, addr_m10=502, addr_m12=500, addr_p1=1; j=511 -> addr_p1=0).
REQ-025 Init latency: init sampled at edge E; ready=1 after edge E+16+1264+1024*STEP_CYCLES (3328 for default).
REQ-026 READY: ready=1; next -> GEN; init -> LOAD.
REQ-027 GEN: one step with update=1, init_mode=0; s_we=1 in last sub-cycle; then -> READY with s_valid=1; keystream latency STEP_CYCLES cycles from the edge sampling next.
REQ-028 s_valid SHALL stay high until the next accepted next or init, and SHALL be low from the first cycle of a new GEN step.
REQ-029 i SHALL continue across GEN steps and wrap 1023 -> 0 (table P).
REQ-030 init in any state other than IDLE (including mid-LOAD/EXPAND/INIT_RUN/GEN) SHALL abort the operation: next cycle is LOAD with expand_idx=0, i=0, s_valid=0, no tbl_we/s_we issued.
REQ-031 init and next asserted together: init wins.
REQ-032 next while busy (not READY) SHALL be ignored and not queued.
REQ-033 At most one of load_we, expand_we, update SHALL be high in any cycle.

Reset
REQ-034 reset SHALL force IDLE, i=0, sub-cycle=0, expand_idx=0, and all outputs to 0, overriding init and next in the same cycle.
REQ-035 reset mid-operation SHALL leave the block unkeyed; the first next after reset SHALL be ignored until init is completed.

Verification
REQ-036 reset, then next pulse -> ready=0, s_valid=0, update never asserts.
REQ-037 init pulse -> load_we high for 16 cycles (idx 0..15), expand_we high for 1264 cycles (idx 16..1279), 1024×2 update cycles with init_mode=1, ready=1 exactly 3328 cycles after init.
REQ-038 after init, next -> s_we at cycle 2, s_valid=1 at cycle 2 with j=0, table_sel=0, addr_m3=509, addr_m10=502, addr_m12=500, addr_p1=1.
REQ-039 1024 consecutive next requests -> table_sel=1 on steps 512..1023; step 1024 reports j=0, table_sel=0.
REQ-040 init asserted during GEN sub-cycle 0 -> no s_we, s_valid=0, LOAD with expand_idx=0 the next cycle.
REQ-041 init and next both asserted in READY -> LOAD entered, no GEN step; reset asserted with init -> IDLE.
